regfile_sext: RTL and testbench

Decode-stage operand unit for the MIPS32 pipeline. It provides a 32-entry x 32-bit register file with two combinational read ports and one synchronous write port. The write port is driven by the writeback stage. The block also contains a purely combinational 16-to-32-bit sign extender for the instruction immediate. Register and immediate outputs feed the ID/EX pipeline register directly.

---
 rtl/regfile_sext.sv | 81 ++++++++
 tb/tb_regfile_sext.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sext.sv
// Decode-stage operand unit: 32 x 32 register file with two combinational read
// ports and one synchronous write port, plus a 16-to-32 immediate sign extender.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset (clears all regs)
//   read_addr_1/2   - read port addresses (rs / rt)
//   write_addr      - write port address from writeback
//   write_data      - write port data
//   write_enabled   - write strobe
//   imm_in          - instruction immediate inst[15:0]
//   data_1/2        - read port data, with same-cycle write-through bypass
//   imm_out         - sign-extended immediate
module regfile_sext #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enabled,
  input  logic [IMM_W-1:0]  imm_in,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] imm_out
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  // Register 0 has no storage; it is the constant zero.
  logic [DATA_W-1:0] regs [1:NREG-1];

  logic              write_live;
  logic              bypass_1;
  logic              bypass_2;
  logic [DATA_W-1:0] stored_1;
  logic [DATA_W-1:0] stored_2;

  // A write that will actually land at the next edge; also gates the bypass.
  assign write_live = !rst && write_enabled && (write_addr != '0);
  assign bypass_1   = write_live && (write_addr == read_addr_1);
  assign bypass_2   = write_live && (write_addr == read_addr_2);

  // Storage update: reset wins over a concurrent write; one-hot write decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (write_live) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (write_addr == ADDR_W'(i)) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  // 32:1 read muxes with entry 0 tied to zero.
  always_comb begin
    stored_1 = '0;
    stored_2 = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (read_addr_1 == ADDR_W'(i)) begin
        stored_1 = regs[i];
      end
      if (read_addr_2 == ADDR_W'(i)) begin
        stored_2 = regs[i];
      end
    end
  end

  assign data_1  = bypass_1 ? write_data : stored_1;
  assign data_2  = bypass_2 ? write_data : stored_2;

  assign imm_out = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in};

endmodule

// File: tb/tb_regfile_sext.sv
// Scoreboard bench for regfile_sext: a driver applies one input vector per
// cycle and queues the expected outputs from an array-based reference model;
// a monitor on the falling edge pops and compares.
module tb_regfile_sext;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_addr_1;
  logic [4:0]  read_addr_2;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enabled;
  logic [15:0] imm_in;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic [31:0] imm_out;

  regfile_sext dut (
    .clk           (clk),
    .rst           (rst),
    .read_addr_1   (read_addr_1),
    .read_addr_2   (read_addr_2),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .write_enabled (write_enabled),
    .imm_in        (imm_in),
    .data_1        (data_1),
    .data_2        (data_2),
    .imm_out       (imm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [0:31];
  int          vectors = 0;
  int          miscompares = 0;

  // Architectural view of a read: r0 is zero, a live write to the same
  // address is visible immediately, otherwise the last committed value.
  function automatic logic [31:0] ref_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (!rst && write_enabled && write_addr == ra) return write_data;
    return model[ra];
  endfunction

  function automatic logic [31:0] ref_sext(input logic [15:0] v);
    if (v >= 16'h8000) return 32'hFFFF0000 + {16'h0, v};
    return {16'h0, v};
  endfunction

  // Commit the inputs present at this rising edge into the model.
  task automatic commit();
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (write_enabled && write_addr != 5'd0) begin
      model[write_addr] = write_data;
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra1,
                      input logic [4:0] ra2, input logic [15:0] imm,
                      input string name);
    exp_t e;
    @(posedge clk);
    commit();
    #1;
    rst = r; write_enabled = we; write_addr = wa; write_data = wd;
    read_addr_1 = ra1; read_addr_2 = ra2; imm_in = imm;
    e.d1 = ref_read(ra1);
    e.d2 = ref_read(ra2);
    e.imm = ref_sext(imm);
    e.name = name;
    sbq.push_back(e);
  endtask

  // Monitor: samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      vectors++;
      if (data_1 !== e.d1) begin
        miscompares++;
        $display("FAIL %s data_1: got %h expected %h", e.name, data_1, e.d1);
      end
      if (data_2 !== e.d2) begin
        miscompares++;
        $display("FAIL %s data_2: got %h expected %h", e.name, data_2, e.d2);
      end
      if (imm_out !== e.imm) begin
        miscompares++;
        $display("FAIL %s imm_out: got %h expected %h", e.name, imm_out, e.imm);
      end
    end
  end

  initial begin
    int drain;
    rst = 1'b1; write_enabled = 1'b0; write_addr = '0; write_data = '0;
    read_addr_1 = '0; read_addr_2 = '0; imm_in = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Initial reset: first edge clears storage; vector holds reset low after.
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 16'h0, "por");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd1, 16'h1234, "post_reset");

    // Reset clear of a written register, then sweep all addresses.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd4, 16'h0, "wr_r5");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 16'h0, "r5_held");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 16'h0, "rst_pulse");
    for (int i = 0; i < 32; i += 2)
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1), 16'h0, "sweep_zero");

    // Basic write/read.
    step(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd1, 5'd2, 16'h0, "wr_r7");
    step(1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd7, 5'd0, 16'h0, "wr_r31");
    step(1'b0, 1'b0, 5'd31, 32'h0, 5'd7, 5'd31, 16'h0, "rd_r7_r31");

    // r0 immutability, including same-cycle read of the write target.
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 16'h0, "wr_r0_same");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 16'h0, "rd_r0");

    // Bypass on both ports to the same address.
    step(1'b0, 1'b1, 5'd3, 32'h11111111, 5'd0, 5'd0, 16'h0, "wr_r3");
    step(1'b0, 1'b1, 5'd3, 32'h22222222, 5'd3, 5'd3, 16'h0, "bypass_r3");
    step(1'b0, 1'b0, 5'd3, 32'h0, 5'd3, 5'd3, 16'h0, "after_bypass");
    step(1'b0, 1'b1, 5'd12, 32'h0BADF00D, 5'd12, 5'd3, 16'h0, "bypass_p1");
    step(1'b0, 1'b1, 5'd3, 32'h33333333, 5'd12, 5'd3, 16'h0, "bypass_p2");

    // Reset priority over write; no bypass while rst is high.
    step(1'b0, 1'b1, 5'd9, 32'h5A5A5A5A, 5'd0, 5'd0, 16'h0, "wr_r9");
    step(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 16'h0, "rst_vs_wr");
    step(1'b0, 1'b0, 5'd9, 32'h0, 5'd9, 5'd3, 16'h0, "r9_cleared");

    // Sign extension, including while reset is held.
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 16'h7FFF, "sext_7fff");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 16'h8000, "sext_8000");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 16'hFFFF, "sext_ffff");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 16'h0000, "sext_0000");

    // Randomized traffic; addresses biased into a small window to collide.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, ra1, ra2;
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      ra2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), wa,
           $urandom, ra1, ra2, 16'($urandom), "random");
    end

    drain = 0;
    while (sbq.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (sbq.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
